// File: rtl/vcache_stats_collector_if.sv
// Snapshot-request and record-stream handshake bundle for vcache_stats_collector.
// master = collector side, slave = requester/consumer side.
interface vcache_stats_collector_if #(
    parameter int num_caches_p = 4,
    parameter int ctr_width_p  = 32,
    parameter int tag_width_p  = 32
);
    localparam int id_width_lp = (num_caches_p > 1) ? $clog2(num_caches_p) : 1;

    logic                   snap_v_i;
    logic [tag_width_p-1:0] snap_tag_i;
    logic                   snap_ready_o;
    logic                   dump_v_o;
    logic                   dump_ready_i;
    logic [id_width_lp-1:0] dump_cache_id_o;
    logic [1:0]             dump_event_id_o;
    logic [ctr_width_p-1:0] dump_count_o;
    logic                   dump_sat_o;
    logic [tag_width_p-1:0] dump_tag_o;
    logic                   dump_last_o;

    modport master (
        input  snap_v_i, snap_tag_i, dump_ready_i,
        output snap_ready_o, dump_v_o, dump_cache_id_o, dump_event_id_o,
               dump_count_o, dump_sat_o, dump_tag_o, dump_last_o
    );

    modport slave (
        output snap_v_i, snap_tag_i, dump_ready_i,
        input  snap_ready_o, dump_v_o, dump_cache_id_o, dump_event_id_o,
               dump_count_o, dump_sat_o, dump_tag_o, dump_last_o
    );
endinterface

// File: rtl/vcache_stats_collector.sv
// Per-channel vcache ld/st/miss event counters with tagged snapshots streamed
// out one (cache, event) record per handshake; counting never stalls.
module vcache_stats_collector #(
    parameter int num_caches_p    = 4,
    parameter int ctr_width_p     = 32,
    parameter int tag_width_p     = 32,
    parameter int clear_on_snap_p = 0
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [num_caches_p-1:0] v_i,
    input  logic [num_caches_p-1:0] yumi_i,
    input  logic [num_caches_p-1:0] ld_op_i,
    input  logic [num_caches_p-1:0] st_op_i,
    input  logic [num_caches_p-1:0] miss_i,
    vcache_stats_collector_if.master bus
);
    localparam int id_width_lp = (num_caches_p > 1) ? $clog2(num_caches_p) : 1;
    localparam logic [ctr_width_p-1:0] ctr_one_lp    = ctr_width_p'(1);
    localparam logic [id_width_lp-1:0] id_one_lp     = id_width_lp'(1);
    localparam logic [id_width_lp-1:0] last_cache_lp = id_width_lp'(num_caches_p - 1);

    typedef enum logic {IDLE, DUMP} state_e;

    logic [num_caches_p-1:0] commit;
    logic [num_caches_p-1:0] ev [4];

    logic [ctr_width_p-1:0] live_cnt   [num_caches_p][4];
    logic                   live_sat   [num_caches_p][4];
    logic [ctr_width_p-1:0] shadow_cnt [num_caches_p][4];
    logic                   shadow_sat [num_caches_p][4];
    logic [tag_width_p-1:0] shadow_tag;

    state_e                 state_r;
    logic [id_width_lp-1:0] rec_cache_r;
    logic [1:0]             rec_event_r;
    logic                   dump_v_r;
    logic                   snap_ready_r;
    logic                   snap_accept;
    logic                   rec_last;

    assign commit = v_i & yumi_i;
    assign ev[0]  = commit & ld_op_i;
    assign ev[1]  = commit & st_op_i;
    assign ev[2]  = commit & ld_op_i & miss_i;
    assign ev[3]  = commit & st_op_i & miss_i;

    assign snap_accept = bus.snap_v_i & snap_ready_r;
    assign rec_last    = (rec_cache_r == last_cache_lp) && (rec_event_r == 2'd3);

    // Saturating live counters; sat marks that at least one event was dropped.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned c = 0; c < num_caches_p; c++) begin
                for (int unsigned e = 0; e < 4; e++) begin
                    live_cnt[c][e] <= '0;
                    live_sat[c][e] <= 1'b0;
                end
            end
        end else begin
            for (int unsigned c = 0; c < num_caches_p; c++) begin
                for (int unsigned e = 0; e < 4; e++) begin
                    if ((clear_on_snap_p != 0) && snap_accept) begin
                        live_cnt[c][e] <= ctr_width_p'(ev[e][c]);
                        live_sat[c][e] <= 1'b0;
                    end else if (ev[e][c]) begin
                        if (&live_cnt[c][e]) begin
                            live_sat[c][e] <= 1'b1;
                        end else begin
                            live_cnt[c][e] <= live_cnt[c][e] + ctr_one_lp;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= IDLE;
            rec_cache_r  <= '0;
            rec_event_r  <= '0;
            dump_v_r     <= 1'b0;
            snap_ready_r <= 1'b1;
            shadow_tag   <= '0;
            for (int unsigned c = 0; c < num_caches_p; c++) begin
                for (int unsigned e = 0; e < 4; e++) begin
                    shadow_cnt[c][e] <= '0;
                    shadow_sat[c][e] <= 1'b0;
                end
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.snap_v_i) begin
                        shadow_cnt   <= live_cnt;
                        shadow_sat   <= live_sat;
                        shadow_tag   <= bus.snap_tag_i;
                        rec_cache_r  <= '0;
                        rec_event_r  <= '0;
                        state_r      <= DUMP;
                        dump_v_r     <= 1'b1;
                        snap_ready_r <= 1'b0;
                    end
                end
                DUMP: begin
                    if (bus.dump_ready_i) begin
                        if (rec_last) begin
                            rec_cache_r  <= '0;
                            rec_event_r  <= '0;
                            state_r      <= IDLE;
                            dump_v_r     <= 1'b0;
                            snap_ready_r <= 1'b1;
                        end else if (rec_event_r == 2'd3) begin
                            rec_cache_r <= rec_cache_r + id_one_lp;
                            rec_event_r <= '0;
                        end else begin
                            rec_event_r <= rec_event_r + 2'd1;
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus.snap_ready_o    = snap_ready_r;
    assign bus.dump_v_o        = dump_v_r;
    assign bus.dump_cache_id_o = dump_v_r ? rec_cache_r : '0;
    assign bus.dump_event_id_o = dump_v_r ? rec_event_r : '0;
    assign bus.dump_count_o    = dump_v_r ? shadow_cnt[rec_cache_r][rec_event_r] : '0;
    assign bus.dump_sat_o      = dump_v_r & shadow_sat[rec_cache_r][rec_event_r];
    assign bus.dump_tag_o      = dump_v_r ? shadow_tag : '0;
    assign bus.dump_last_o     = dump_v_r & rec_last;
endmodule

// File: tb/tb_vcache_stats_collector.sv
// Randomized + directed bench: two collectors (hold / clear-on-snapshot) on shared
// stimulus, checked against a queue-of-records model built from plain event totals.
module tb_vcache_stats_collector;
    localparam int N    = 4;
    localparam int CW   = 8;
    localparam int TW   = 16;
    localparam int CMAX = 255;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] v, yumi, ld, st, miss;

    vcache_stats_collector_if #(.num_caches_p(N), .ctr_width_p(CW), .tag_width_p(TW)) bus0 ();
    vcache_stats_collector_if #(.num_caches_p(N), .ctr_width_p(CW), .tag_width_p(TW)) bus1 ();

    vcache_stats_collector #(
        .num_caches_p(N), .ctr_width_p(CW), .tag_width_p(TW), .clear_on_snap_p(0)
    ) dut0 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .yumi_i(yumi),
        .ld_op_i(ld), .st_op_i(st), .miss_i(miss), .bus(bus0)
    );

    vcache_stats_collector #(
        .num_caches_p(N), .ctr_width_p(CW), .tag_width_p(TW), .clear_on_snap_p(1)
    ) dut1 (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .yumi_i(yumi),
        .ld_op_i(ld), .st_op_i(st), .miss_i(miss), .bus(bus1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cache;
        int ev;
        int cnt;
        bit sat;
        int tag;
        bit last;
    } rec_t;

    rec_t q0[$];
    rec_t q1[$];
    int   tot0 [N][4];
    int   tot1 [N][4];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    function automatic rec_t mk_rec(input int c, input int e, input int cnt, input int tag);
        rec_t r;
        r.cache = c;
        r.ev    = e;
        r.cnt   = (cnt > CMAX) ? CMAX : cnt;
        r.sat   = (cnt > CMAX);
        r.tag   = tag;
        r.last  = (c == N - 1) && (e == 3);
        return r;
    endfunction

    task automatic check_port(input string p, input logic dv, input logic sr,
                              input logic [1:0] cid, input logic [1:0] eid,
                              input logic [CW-1:0] cnt, input logic sat,
                              input logic [TW-1:0] tag, input logic last,
                              input bit busy, input rec_t r);
        check_eq({p, ".dump_v"}, dv, busy);
        check_eq({p, ".snap_ready"}, sr, !busy);
        if (busy) begin
            check_eq({p, ".cache_id"}, cid, r.cache);
            check_eq({p, ".event_id"}, eid, r.ev);
            check_eq({p, ".count"}, cnt, r.cnt);
            check_eq({p, ".sat"}, sat, r.sat);
            check_eq({p, ".tag"}, tag, r.tag);
            check_eq({p, ".last"}, last, r.last);
        end
    endtask

    task automatic check_all();
        rec_t r0, r1;
        r0 = '{default: 0};
        r1 = r0;
        if (q0.size() != 0) r0 = q0[0];
        if (q1.size() != 0) r1 = q1[0];
        check_port("hold", bus0.dump_v_o, bus0.snap_ready_o, bus0.dump_cache_id_o,
                   bus0.dump_event_id_o, bus0.dump_count_o, bus0.dump_sat_o,
                   bus0.dump_tag_o, bus0.dump_last_o, q0.size() != 0, r0);
        check_port("clear", bus1.dump_v_o, bus1.snap_ready_o, bus1.dump_cache_id_o,
                   bus1.dump_event_id_o, bus1.dump_count_o, bus1.dump_sat_o,
                   bus1.dump_tag_o, bus1.dump_last_o, q1.size() != 0, r1);
    endtask

    task automatic check_reset_state(input string p, input logic dv, input logic sr,
                                     input logic [CW-1:0] cnt, input logic sat,
                                     input logic [TW-1:0] tag, input logic last);
        check_eq({p, ".rst_dump_v"}, dv, 0);
        check_eq({p, ".rst_snap_ready"}, sr, 1);
        check_eq({p, ".rst_count"}, cnt, 0);
        check_eq({p, ".rst_sat"}, sat, 0);
        check_eq({p, ".rst_tag"}, tag, 0);
        check_eq({p, ".rst_last"}, last, 0);
    endtask

    // Apply one cycle of inputs, advance the model by the same cycle, clock, then check.
    task automatic cyc(input logic [N-1:0] iv, input logic [N-1:0] iy, input logic [N-1:0] il,
                       input logic [N-1:0] is, input logic [N-1:0] im, input logic sv,
                       input logic [TW-1:0] tag, input logic rdy);
        bit idle;
        bit acc;
        int inc;
        v = iv; yumi = iy; ld = il; st = is; miss = im;
        bus0.snap_v_i = sv; bus0.snap_tag_i = tag; bus0.dump_ready_i = rdy;
        bus1.snap_v_i = sv; bus1.snap_tag_i = tag; bus1.dump_ready_i = rdy;
        idle = (q0.size() == 0);
        acc  = idle && sv;
        if (!idle && rdy) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
        end
        if (acc) begin
            for (int c = 0; c < N; c++) begin
                for (int e = 0; e < 4; e++) begin
                    q0.push_back(mk_rec(c, e, tot0[c][e], int'(tag)));
                    q1.push_back(mk_rec(c, e, tot1[c][e], int'(tag)));
                end
            end
        end
        for (int c = 0; c < N; c++) begin
            for (int e = 0; e < 4; e++) begin
                inc = 0;
                if (iv[c] && iy[c]) begin
                    case (e)
                        0: inc = int'(il[c]);
                        1: inc = int'(is[c]);
                        2: inc = int'(il[c] & im[c]);
                        default: inc = int'(is[c] & im[c]);
                    endcase
                end
                tot0[c][e] = tot0[c][e] + inc;
                tot1[c][e] = acc ? inc : tot1[c][e] + inc;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drain(input bit toggle, input bit chk29, input int expect_n);
        int   k;
        int   guard;
        int   want;
        int   t29[4];
        logic r;
        k = 0;
        guard = 0;
        t29 = '{3, 2, 1, 0};
        while (q0.size() != 0 && guard < 300) begin
            r = (toggle && (guard % 2 == 1)) ? 1'b0 : 1'b1;
            if (r) begin
                if (chk29) begin
                    want = (k / 4 == 1) ? t29[k % 4] : 0;
                    check_eq("req29_count_hold", bus0.dump_count_o, want);
                    check_eq("req29_count_clear", bus1.dump_count_o, want);
                    check_eq("req29_tag", bus0.dump_tag_o, 'hA5);
                end
                k++;
            end
            cyc('0, '0, '0, '0, '0, 1'b0, '0, r);
            guard++;
        end
        check_eq("drain_empty", q0.size(), 0);
        if (expect_n >= 0) check_eq("drain_records", k, expect_n);
    endtask

    initial begin
        reset_n = 1'b0;
        v = '0; yumi = '0; ld = '0; st = '0; miss = '0;
        bus0.snap_v_i = 1'b0; bus0.snap_tag_i = '0; bus0.dump_ready_i = 1'b0;
        bus1.snap_v_i = 1'b0; bus1.snap_tag_i = '0; bus1.dump_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("hold", bus0.dump_v_o, bus0.snap_ready_o, bus0.dump_count_o,
                          bus0.dump_sat_o, bus0.dump_tag_o, bus0.dump_last_o);
        check_reset_state("clear", bus1.dump_v_o, bus1.snap_ready_o, bus1.dump_count_o,
                          bus1.dump_sat_o, bus1.dump_tag_o, bus1.dump_last_o);
        reset_n = 1'b1;

        // Channel 1: 3 ld (1 miss), 2 st, then valid without accept.
        repeat (2) cyc(4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0, '0, 1'b0);
        cyc(4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, '0, 1'b0);
        repeat (2) cyc(4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0, '0, 1'b0);
        repeat (5) cyc(4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 1'b0, '0, 1'b0);
        cyc('0, '0, '0, '0, '0, 1'b1, 16'h00A5, 1'b0);
        drain(1'b0, 1'b1, 16);

        // Saturation of an 8-bit counter, then a ready-toggled dump.
        repeat (300) cyc(4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, '0, 1'b0);
        cyc('0, '0, '0, '0, '0, 1'b1, 16'h0030, 1'b0);
        check_eq("req30_count_hold", bus0.dump_count_o, 255);
        check_eq("req30_sat_hold", bus0.dump_sat_o, 1);
        check_eq("req30_count_clear", bus1.dump_count_o, 255);
        drain(1'b1, 1'b0, 16);

        // ld on channel 2 in the accept cycle lands in the next snapshot only.
        cyc(4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b1, 16'h0032, 1'b0);
        drain(1'b0, 1'b0, 16);
        cyc('0, '0, '0, '0, '0, 1'b1, 16'h0033, 1'b0);
        repeat (8) cyc('0, '0, '0, '0, '0, 1'b0, '0, 1'b1);
        check_eq("req32_cache_id", bus1.dump_cache_id_o, 2);
        check_eq("req32_event_id", bus1.dump_event_id_o, 0);
        check_eq("req32_count", bus1.dump_count_o, 1);
        drain(1'b0, 1'b0, 8);

        // Snapshot request held high across a whole dump.
        repeat (20) cyc('0, '0, '0, '0, '0, 1'b1, 16'h0040, 1'b1);
        drain(1'b0, 1'b0, -1);

        // Reset while record 5 is presented.
        repeat (10) cyc(N'($urandom), N'($urandom), N'($urandom), N'($urandom),
                        N'($urandom), 1'b0, '0, 1'b0);
        cyc('0, '0, '0, '0, '0, 1'b1, 16'h0050, 1'b0);
        repeat (5) cyc('0, '0, '0, '0, '0, 1'b0, '0, 1'b1);
        check_eq("req34_cache_id", bus0.dump_cache_id_o, 1);
        check_eq("req34_event_id", bus0.dump_event_id_o, 1);
        #1 reset_n = 1'b0;
        #1;
        check_reset_state("hold_mid", bus0.dump_v_o, bus0.snap_ready_o, bus0.dump_count_o,
                          bus0.dump_sat_o, bus0.dump_tag_o, bus0.dump_last_o);
        check_reset_state("clear_mid", bus1.dump_v_o, bus1.snap_ready_o, bus1.dump_count_o,
                          bus1.dump_sat_o, bus1.dump_tag_o, bus1.dump_last_o);
        q0.delete();
        q1.delete();
        for (int c = 0; c < N; c++) begin
            for (int e = 0; e < 4; e++) begin
                tot0[c][e] = 0;
                tot1[c][e] = 0;
            end
        end
        bus0.snap_v_i = 1'b0; bus0.dump_ready_i = 1'b1;
        bus1.snap_v_i = 1'b0; bus1.dump_ready_i = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) cyc('0, '0, '0, '0, '0, 1'b0, '0, 1'b1);
        cyc('0, '0, '0, '0, '0, 1'b1, 16'h0051, 1'b0);
        drain(1'b0, 1'b0, 16);

        // Random traffic with random snapshots and consumer back-pressure.
        repeat (1500) begin
            cyc(N'($urandom), N'($urandom), N'($urandom), N'($urandom), N'($urandom),
                $urandom_range(0, 19) == 0, TW'($urandom), $urandom_range(0, 3) != 0);
        end
        drain(1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vcache_stats_collector.md
VCACHE_STATS_COLLECTOR -- requirements
Module: vcache_stats_collector

Interface
REQ-001 SHALL have parameter num_caches_p, default 4, number of monitored vcache channels (1..64).
REQ-002 SHALL have parameter ctr_width_p, default 32, width of each event counter (8..64).
REQ-003 SHALL have parameter tag_width_p, default 32, width of snapshot tag.
REQ-004 SHALL have parameter clear_on_snap_p, default 0, 1 = live counters restart from zero at each snapshot.
REQ-005 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset_n_i  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port v_i  input  num_caches_p  per-channel cache output valid.
REQ-008 SHALL have port yumi_i  input  num_caches_p  per-channel consumer accept.
REQ-009 SHALL have ports ld_op_i, st_op_i, miss_i  input  num_caches_p each  per-channel decoded op and miss flags.
REQ-010 SHALL have port snap_v_i  input  1  snapshot request.
REQ-011 SHALL have port snap_tag_i  input  tag_width_p  tag attached to the snapshot.
REQ-012 SHALL have port snap_ready_o  output  1  snapshot request may be accepted.
REQ-013 SHALL have ports dump_v_o output 1, dump_ready_i input 1  record stream handshake.
REQ-014 SHALL have ports dump_cache_id_o  output  clog2(num_caches_p), min 1; dump_event_id_o  output  2; dump_count_o  output  ctr_width_p; dump_sat_o  output  1; dump_tag_o  output  tag_width_p; dump_last_o  output  1.

Function
REQ-015 SHALL define per-channel commit = v_i & yumi_i; events: 0 ld (commit & ld_op_i), 1 st (commit & st_op_i), 2 ld_miss (ld & miss_i), 3 st_miss (st & miss_i).
REQ-016 SHALL count ld and st independently if both asserted; no event without commit.
REQ-017 SHALL keep live counters that saturate at all-ones and set a per-counter sticky sat flag; never wrap.
REQ-018 SHALL implement FSM IDLE/DUMP; snap_ready_o = 1 only in IDLE.
REQ-019 SHALL accept a snapshot on snap_v_i & snap_ready_o; copy all live counters and sat flags (pre-increment values of that cycle) and snap_tag_i into shadow registers; enter DUMP next cycle.
REQ-020 SHALL, on accept with clear_on_snap_p=1, load each live counter with its same-cycle increment (0 or 1) and clear sat flags; with 0, live counters continue incrementing unchanged.
REQ-021 SHALL ignore snap_v_i while in DUMP (no capture, no queuing).
REQ-022 SHALL in DUMP assert dump_v_o and present shadow record (cache c, event e), order c=0..N-1 outer, e=0..3 inner, starting at (0,0).
REQ-023 SHALL hold all dump outputs stable while dump_v_o & ~dump_ready_i; advance one record per handshake, max one record per cycle.
REQ-024 SHALL assert dump_last_o only on record (num_caches_p-1, 3); its handshake returns FSM to IDLE next cycle, dump_v_o low.
REQ-025 SHALL continue live counting every cycle regardless of FSM state; dump never stalls counting.
REQ-026 SHALL keep dump_tag_o equal to captured tag for every record of the snapshot.

Reset
REQ-027 SHALL on reset_n_i low immediately clear live counters, sat flags, shadow registers, record index, FSM to IDLE; dump_v_o = 0, snap_ready_o = 1, dump outputs 0.
REQ-028 SHALL abort any dump in progress on reset; no further records emitted after reset deasserts.

Verification
REQ-029 Channel 1: 3 ld commits (1 miss), 2 st commits, v_i without yumi_i 5 cycles; snap tag 0xA5 -> record (1,0..3) = 3,2,1,0, tag 0xA5, others 0.
REQ-030 ctr_width_p=8: 300 ld commits on channel 0 -> dump_count_o=255, dump_sat_o=1 for (0,0).
REQ-031 dump_ready_i toggling 1/0 for num_caches_p=4 -> exactly 16 records in order, outputs stable during stalls, dump_last_o only on 16th.
REQ-032 clear_on_snap_p=1, ld commit on channel 2 in snapshot-accept cycle -> that ld absent from dump, next snapshot shows ld=1.
REQ-033 snap_v_i held high throughout dump -> snap_ready_o=0 until after last handshake, second snapshot accepted first IDLE cycle.
REQ-034 reset_n_i pulsed low mid-dump (record 5) -> dump_v_o falls immediately, all counts 0 on next snapshot.
